mac_result_requant: RTL and testbench

- Downstream consumer of the 16-column MAC array's 17-bit signed column results.
- Snapshots all column results on a capture strobe, then scans the enabled columns one per cycle: adds a per-column bias, applies an arithmetic right shift and saturates to int8.
- Pushes each result into an output FIFO drained with a valid/ready handshake, feeding the next layer's data staging.

---
 rtl/mac_result_requant.sv | 179 +++++++++++++++++
 tb/tb_mac_result_requant.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_requant.sv
// mac_result_requant: snapshots the 16 MAC column results, adds a per-column
// bias, shifts right arithmetically, saturates to int8 and queues the results
// in a first-word-fall-through FIFO with a valid/ready drain.
// Optional feature macro: MAC_REQUANT_RELU_EN (ReLU after shift, range [0,127]).
module mac_result_requant #(
   parameter int NCOL       = 16,
   parameter int IN_W       = 17,
   parameter int OUT_W      = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  Clk,
   input  logic                  reset,
   input  logic [NCOL*IN_W-1:0]  macIn,
   input  logic [NCOL-1:0]       colMask,
   input  logic                  capture,
   input  logic [3:0]            shiftAmt,
   input  logic                  biasWE,
   input  logic [3:0]            biasAddr,
   input  logic [IN_W-1:0]       biasData,
   output logic [OUT_W-1:0]      outData,
   output logic [3:0]            outCol,
   output logic                  outSat,
   output logic                  outValid,
   input  logic                  outReady,
   output logic                  busy,
   output logic                  captureErr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 1 + 4 + OUT_W;
   localparam logic signed [IN_W:0] SMAX = (IN_W+1)'(2**(OUT_W-1) - 1);
   localparam logic signed [IN_W:0] SMIN = ~SMAX;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                       state, state_nx;
   logic [3:0]                   col, col_nx;
   logic                         start;
   logic [NCOL-1:0][IN_W-1:0]    snap_mac;
   logic [NCOL-1:0]              snap_mask;
   logic [3:0]                   snap_shift;
   logic [NCOL-1:0][IN_W-1:0]    bias;
   logic [31:0]                  addr_ext;

   logic [EW-1:0]                mem [FIFO_DEPTH];
   logic [AW-1:0]                wr_ptr, rd_ptr;
   logic [AW:0]                  count;
   logic                         full, push, pop;
   logic [EW-1:0]                head;

   logic signed [IN_W-1:0]       mac_c, bias_c;
   logic signed [IN_W:0]         sum, shifted;
   logic [OUT_W-1:0]             res;
   logic                         res_sat;

   assign busy     = (state == SCAN);
   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign outValid = (count != '0);
   assign pop      = outValid && outReady;
   // A push blocked by a full FIFO waits even if a pop frees a slot this cycle.
   assign push     = (state == SCAN) && snap_mask[col] && !full;
   assign addr_ext = 32'(biasAddr);

   // State and column register.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         col   <= '0;
      end else begin
         state <= state_nx;
         col   <= col_nx;
      end
   end

   // Next state: a scan visits every column once, stalling only on a full FIFO.
   always_comb begin
      state_nx = state;
      col_nx   = col;
      start    = 1'b0;
      case (state)
         IDLE: begin
            if (capture) begin
               state_nx = SCAN;
               col_nx   = '0;
               start    = 1'b1;
            end
         end
         SCAN: begin
            if (!(snap_mask[col] && full)) begin
               if (col == 4'(NCOL-1)) state_nx = IDLE;
               col_nx = col + 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Snapshot of the column results, mask and shift taken at scan start.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         snap_mac   <= '0;
         snap_mask  <= '0;
         snap_shift <= '0;
      end else if (start) begin
         snap_mac   <= macIn;
         snap_mask  <= colMask;
         snap_shift <= shiftAmt;
      end
   end

   // Bias registers are writable only while idle so a scan sees stable biases.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) bias <= '0;
      else if (biasWE && state == IDLE && addr_ext < NCOL) bias[biasAddr] <= biasData;
   end

   // A capture arriving while a scan runs is dropped and flagged for one cycle.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) captureErr <= 1'b0;
      else       captureErr <= capture && (state == SCAN);
   end

   // Requantise the current column: bias add, arithmetic shift, clip.
   always_comb begin
      mac_c   = $signed(snap_mac[col]);
      bias_c  = $signed(bias[col]);
      sum     = {mac_c[IN_W-1], mac_c} + {bias_c[IN_W-1], bias_c};
      shifted = sum >>> snap_shift;
      res     = shifted[OUT_W-1:0];
      res_sat = 1'b0;
`ifdef MAC_REQUANT_RELU_EN
      if (shifted[IN_W]) begin
         res = '0;
      end else if (shifted > SMAX) begin
         res     = SMAX[OUT_W-1:0];
         res_sat = 1'b1;
      end
`else
      if (shifted > SMAX) begin
         res     = SMAX[OUT_W-1:0];
         res_sat = 1'b1;
      end else if (shifted < SMIN) begin
         res     = SMIN[OUT_W-1:0];
         res_sat = 1'b1;
      end
`endif
   end

   // FIFO storage; contents are don't-care until counted valid.
   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= {res_sat, col, res};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Head entry, forced to zero when the FIFO is empty.
   always_comb begin
      head    = outValid ? mem[rd_ptr] : '0;
      outData = head[OUT_W-1:0];
      outCol  = head[OUT_W +: 4];
      outSat  = head[EW-1];
   end

endmodule

// File: tb/tb_mac_result_requant.sv
// Randomised bench for mac_result_requant with a queue-based reference model.
module tb_mac_result_requant;
   localparam int NCOL = 16;
   localparam int IN_W = 17;
   localparam int OUT_W = 8;

   logic                 Clk = 1'b0;
   logic                 reset = 1'b1;
   logic [NCOL*IN_W-1:0] macIn = '0;
   logic [NCOL-1:0]      colMask = '0;
   logic                 capture = 1'b0;
   logic [3:0]           shiftAmt = '0;
   logic                 biasWE = 1'b0;
   logic [3:0]           biasAddr = '0;
   logic [IN_W-1:0]      biasData = '0;
   logic [OUT_W-1:0]     outData;
   logic [3:0]           outCol;
   logic                 outSat, outValid, busy, captureErr;
   logic                 outReady = 1'b0;

   mac_result_requant dut (
      .Clk(Clk), .reset(reset), .macIn(macIn), .colMask(colMask), .capture(capture),
      .shiftAmt(shiftAmt), .biasWE(biasWE), .biasAddr(biasAddr), .biasData(biasData),
      .outData(outData), .outCol(outCol), .outSat(outSat), .outValid(outValid),
      .outReady(outReady), .busy(busy), .captureErr(captureErr)
   );

   always #5 Clk = ~Clk;

   typedef struct { int data; int col; int sat; } ent_t;
   ent_t exp_q[$];
   ent_t me;
   int   bias_m [NCOL];
   int   nchk = 0, nfail = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      nchk++;
      if (obs != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: every enabled column, in order, biased, shifted, clipped.
   function automatic void model_cap(input logic [NCOL*IN_W-1:0] mac,
                                     input logic [NCOL-1:0] mask, input int sh);
      for (int c = 0; c < NCOL; c++) begin
         if (mask[c]) begin
            int m = $signed(mac[c*IN_W +: IN_W]);
            int v = (m + bias_m[c]) >>> sh;
            int s = 0;
`ifdef MAC_REQUANT_RELU_EN
            if (v < 0) v = 0;
`endif
            if (v > 127) begin v = 127; s = 1; end
            else if (v < -128) begin v = -128; s = 1; end
            exp_q.push_back('{data: v, col: c, sat: s});
         end
      end
   endfunction

   // Pops are checked in mid-cycle against the model queue.
   always @(negedge Clk) begin
      if (!reset) begin
         if (outValid && outReady) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
            else begin
               me = exp_q.pop_front();
               chk("pop_data", $signed(outData), me.data);
               chk("pop_col", int'(outCol), me.col);
               chk("pop_sat", int'(outSat), me.sat);
            end
         end else if (!outValid) begin
            chk("empty_zero", int'({outData, outCol, outSat}), 0);
         end
      end
   end

   task automatic tick();
      @(posedge Clk); #1;
   endtask

   task automatic wr_bias(input int a, input int d);
      logic signed [IN_W-1:0] bd;
      bit ok;
      bd = IN_W'(d);
      ok = !busy;
      biasAddr = 4'(a); biasData = bd; biasWE = 1'b1;
      tick();
      biasWE = 1'b0;
      if (ok) bias_m[a] = bd;
   endtask

   task automatic cap(input logic [NCOL*IN_W-1:0] mac, input logic [NCOL-1:0] mask,
                      input int sh);
      bit was_busy;
      was_busy = busy;
      macIn = mac; colMask = mask; shiftAmt = 4'(sh); capture = 1'b1;
      tick();
      capture = 1'b0;
      chk("capture_err", int'(captureErr), int'(was_busy));
      if (!was_busy) model_cap(mac, mask, sh);
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      while ((busy || outValid) && n < 3000) begin
         outReady = rnd ? 1'($urandom) : 1'b1;
         tick();
         n++;
      end
      outReady = 1'b0;
      chk("drain_done", int'(n < 3000), 1);
      chk("drain_q", exp_q.size(), 0);
   endtask

   task automatic wait_head(input string tag, input int d, input int c, input int s);
      int n = 0;
      while (!outValid && n < 40) begin tick(); n++; end
      chk({tag, "_valid"}, int'(outValid), 1);
      chk({tag, "_data"}, $signed(outData), d);
      chk({tag, "_col"}, int'(outCol), c);
      chk({tag, "_sat"}, int'(outSat), s);
   endtask

   function automatic logic [NCOL*IN_W-1:0] rnd_mac();
      logic [NCOL*IN_W-1:0] m;
      for (int c = 0; c < NCOL; c++) begin
         int v = ($urandom % 2) ? int'($urandom_range(0, 600)) - 300 : int'($urandom);
         m[c*IN_W +: IN_W] = IN_W'(v);
      end
      return m;
   endfunction

   function automatic int rnd_bias();
      logic signed [IN_W-1:0] b;
      b = ($urandom % 2) ? IN_W'(int'($urandom_range(0, 200)) - 100) : IN_W'($urandom);
      return int'(b);
   endfunction

   initial begin
      logic [NCOL*IN_W-1:0] m;
      int v;
      for (int i = 0; i < NCOL; i++) bias_m[i] = 0;

      // Reset state
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(captureErr), 0);
      chk("rst_valid", int'(outValid), 0);
      chk("rst_head", int'({outData, outCol, outSat}), 0);
      reset = 1'b0;
      tick();

      // Bias add, latency and scan length
      wr_bias(0, 5);
      m = '0; m[0 +: IN_W] = IN_W'(7);
      cap(m, 16'h0001, 0);
      chk("t1_busy_e0", int'(busy), 1);
      chk("t1_valid_e0", int'(outValid), 0);
      tick();
      chk("t1_valid_e1", int'(outValid), 1);
      chk("t1_data", $signed(outData), 12);
      chk("t1_col", int'(outCol), 0);
      chk("t1_sat", int'(outSat), 0);
      repeat (14) tick();
      chk("t1_busy_e15", int'(busy), 1);
      tick();
      chk("t1_busy_e16", int'(busy), 0);
      drain(0);

      // Negative clip on column 15
      m = '0; v = -146; m[15*IN_W +: IN_W] = IN_W'(v);
      cap(m, 16'h8000, 0);
`ifdef MAC_REQUANT_RELU_EN
      wait_head("t2", 0, 15, 0);
`else
      wait_head("t2", -128, 15, 1);
`endif
      drain(0);

      // Shift versus positive clip
      m = '0; m[1*IN_W +: IN_W] = IN_W'(400);
      cap(m, 16'h0002, 2);
      wait_head("t3a", 100, 1, 0);
      drain(0);
      cap(m, 16'h0002, 0);
      wait_head("t3b", 127, 1, 1);
      drain(0);

      // Fill FIFO, then stall a second scan and a rejected capture
      cap(rnd_mac(), 16'hFFFF, $urandom_range(0, 15));
      repeat (16) tick();
      chk("fill_busy", int'(busy), 0);
      chk("fill_valid", int'(outValid), 1);
      cap(rnd_mac(), 16'hFFFF, $urandom_range(0, 15));
      repeat (3) tick();
      chk("stall_busy", int'(busy), 1);
      cap(rnd_mac(), 16'hFFFF, 0);
      tick();
      chk("err_one_cycle", int'(captureErr), 0);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      tick();
      chk("stall_busy2", int'(busy), 1);
      drain(1);

      // Reset in the middle of a scan
      for (int i = 0; i < NCOL; i++) wr_bias(i, rnd_bias());
      cap(rnd_mac(), 16'hFFFF, $urandom_range(0, 15));
      repeat (5) tick();
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", int'(outValid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      exp_q.delete();
      for (int i = 0; i < NCOL; i++) bias_m[i] = 0;
      tick();
      reset = 1'b0;
      tick();
      cap(rnd_mac(), NCOL'($urandom) | 16'h0001, $urandom_range(0, 15));
      drain(1);

      // Random scans with stray bias writes and captures during the scan
      for (int it = 0; it < 40; it++) begin
         if ($urandom % 2) wr_bias($urandom_range(0, NCOL-1), rnd_bias());
         outReady = 1'($urandom);
         cap(rnd_mac(), NCOL'($urandom), $urandom_range(0, 15));
         macIn = rnd_mac(); colMask = NCOL'($urandom); shiftAmt = 4'($urandom);
         for (int k = 0; k < 4; k++) begin
            outReady = 1'($urandom);
            case ($urandom % 3)
               0: wr_bias($urandom_range(0, NCOL-1), rnd_bias());
               1: cap(rnd_mac(), NCOL'($urandom), $urandom_range(0, 15));
               default: tick();
            endcase
         end
         drain(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", nchk);
      $fatal(1);
   end
endmodule
